// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator with pixel-enable divider and a latency-matched pin stage.
// Optional colour-bar test pattern enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int XW       = 10,
    parameter int YW       = 10,
    parameter int RGB_LAT  = 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          o_pix_ce,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_de_early,
    output logic          o_line_start,
    output logic          o_frame_start,
    input  logic [11:0]   i_rgb_in,
    input  logic          i_test_mode,
    output logic          o_hs,
    output logic          o_vs,
    output logic [3:0]    o_r,
    output logic [3:0]    o_g,
    output logic [3:0]    o_b
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef VGA_TEST_PATTERN_EN
    localparam int PW = XW + 3;
`else
    localparam int PW = 3;
`endif

    generate
        if (CLK_DIV < 1 || RGB_LAT < 0 || RGB_LAT > 7) begin : g_bad_div_lat
            $error("vga_timing_gen: CLK_DIV must be >=1 and RGB_LAT 0..7");
        end
        if (H_TOTAL > (1 << XW) || V_TOTAL > (1 << YW)) begin : g_bad_width
            $error("vga_timing_gen: XW/YW too narrow for H_TOTAL/V_TOTAL");
        end
        if (H_ACTIVE == 0 || H_SYNC == 0 || V_ACTIVE == 0 || V_SYNC == 0) begin : g_bad_zero
            $error("vga_timing_gen: active and sync parameters must be non-zero");
        end
    endgenerate

    logic [DW-1:0] r_div;
    logic          r_pix_ce;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_de, r_ls, r_fs;
    logic          r_hs, r_vs;
    logic [11:0]   r_rgb;

    logic          w_tick, w_xwrap, w_ywrap;
    logic [XW-1:0] w_xn;
    logic [YW-1:0] w_yn;
    logic          w_hs_raw, w_vs_raw;
    logic [PW-1:0] w_raw, w_dly;
    logic [11:0]   w_pix;

    assign w_tick   = r_div == DW'(CLK_DIV - 1);
    assign w_xwrap  = int'(r_x) == H_TOTAL - 1;
    assign w_ywrap  = int'(r_y) == V_TOTAL - 1;
    assign w_xn     = !r_pix_ce ? r_x : w_xwrap ? '0 : r_x + 1'b1;
    assign w_yn     = !(r_pix_ce && w_xwrap) ? r_y : w_ywrap ? '0 : r_y + 1'b1;
    assign w_hs_raw = int'(r_x) >= HS_START && int'(r_x) < HS_END;
    assign w_vs_raw = int'(r_y) >= VS_START && int'(r_y) < VS_END;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]  w_bar;
    logic [11:0] w_pat;
    assign w_raw = {r_x, w_hs_raw, w_vs_raw, r_de};
    assign w_bar = 3'((int'(w_dly[PW-1:3]) * 8) / H_ACTIVE);
    assign w_pat = {{4{~w_bar[1]}}, {4{~w_bar[2]}}, {4{~w_bar[0]}}};
    assign w_pix = !w_dly[0] ? '0 : i_test_mode ? w_pat : i_rgb_in;
`else
    logic w_unused;
    assign w_unused = i_test_mode;
    assign w_raw    = {w_hs_raw, w_vs_raw, r_de};
    assign w_pix    = w_dly[0] ? i_rgb_in : '0;
`endif

    // Sync/DE (and x for the pattern) ride a pix_ce-clocked pipe to meet the renderer's rgb latency.
    generate
        if (RGB_LAT == 0) begin : g_nolat
            assign w_dly = w_raw;
        end else begin : g_lat
            logic [PW-1:0] r_pipe [RGB_LAT];
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < RGB_LAT; i++) r_pipe[i] <= '0;
                end else if (r_pix_ce) begin
                    r_pipe[0] <= w_raw;
                    for (int i = 1; i < RGB_LAT; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign w_dly = r_pipe[RGB_LAT-1];
        end
    endgenerate

    // Strobes also load on the divider tick so the very first pix_ce already shows x=0,y=0 flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div    <= '0;
            r_pix_ce <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_de     <= 1'b0;
            r_ls     <= 1'b0;
            r_fs     <= 1'b0;
            r_hs     <= ~HS_POL;
            r_vs     <= ~VS_POL;
            r_rgb    <= '0;
        end else begin
            r_div    <= w_tick ? '0 : r_div + 1'b1;
            r_pix_ce <= w_tick;
            r_x      <= w_xn;
            r_y      <= w_yn;
            if (r_pix_ce || w_tick) begin
                r_de <= int'(w_xn) < H_ACTIVE && int'(w_yn) < V_ACTIVE;
                r_ls <= w_xn == '0;
                r_fs <= w_xn == '0 && w_yn == '0;
            end
            if (r_pix_ce) begin
                r_hs  <= w_dly[2] ? HS_POL : ~HS_POL;
                r_vs  <= w_dly[1] ? VS_POL : ~VS_POL;
                r_rgb <= w_pix;
            end
        end
    end

    assign o_pix_ce      = r_pix_ce;
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_de_early    = r_de;
    assign o_line_start  = r_ls;
    assign o_frame_start = r_fs;
    assign o_hs          = r_hs;
    assign o_vs          = r_vs;
    assign {o_r, o_g, o_b} = r_rgb;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized scoreboard bench for vga_timing_gen on a small raster.
// Expected pixels come from pixel-index arithmetic; a monitor pops them on each pix_ce.
module tb_vga_timing_gen;
    localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
    localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
    localparam int CD = 2, LAT = 2, XW = 4, YW = 3;
    localparam bit HP = 1'b0, VP = 1'b1;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;

    logic clk = 1'b0, rst = 1'b0;
    logic [11:0] rgb_in = '0;
    logic test_mode = 1'b0;
    logic pix_ce, de_early, line_start, frame_start, hs, vs;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [3:0] r, g, b;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .CLK_DIV(CD), .HS_POL(HP), .VS_POL(VP), .XW(XW), .YW(YW), .RGB_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .o_pix_ce(pix_ce), .o_x(x), .o_y(y),
        .o_de_early(de_early), .o_line_start(line_start), .o_frame_start(frame_start),
        .i_rgb_in(rgb_in), .i_test_mode(test_mode),
        .o_hs(hs), .o_vs(vs), .o_r(r), .o_g(g), .o_b(b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [2:0]    st;
        logic [1:0]    sy;
        logic [11:0]   rgb;
    } exp_t;

    exp_t        q[$];
    logic [11:0] hist[$];
    bit          tmh[$];
    int          total = 0, bad = 0;
    int          t0 = 0;
    exp_t        e;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] colour(int n, int xm);
        logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                  12'hF0F, 12'hF00, 12'h00F, 12'h000};
`ifdef VGA_TEST_PATTERN_EN
        if (tmh[n]) return bars[xm * 8 / HA];
`endif
        if (xm < 0) return bars[0];
        return hist[n];
    endfunction

    function automatic exp_t model(int n, int c);
        exp_t t;
        int xn, yn, m, xm, ym;
        bit hsa, vsa;
        xn = n % HT;
        yn = (n / HT) % VT;
        t.cyc = c;
        t.x = XW'(xn);
        t.y = YW'(yn);
        t.st = {xn < HA && yn < VA, xn == 0, xn == 0 && yn == 0};
        t.sy = {~HP, ~VP};
        t.rgb = '0;
        if (n > LAT) begin
            m = n - LAT - 1;
            xm = m % HT;
            ym = (m / HT) % VT;
            hsa = xm >= HA + HF && xm < HA + HF + HSW;
            vsa = ym >= VA + VF && ym < VA + VF + VSW;
            t.sy = {hsa ? HP : ~HP, vsa ? VP : ~VP};
            if (xm < HA && ym < VA) t.rgb = colour(n - 1, xm);
        end
        return t;
    endfunction

    task automatic do_reset(int nclk);
        rst = 1'b0;
        repeat (nclk) begin
            @(posedge clk);
            #1;
            chk("reset_state",
                {pix_ce, x, y, de_early, line_start, frame_start, hs, vs, r, g, b},
                {1'b0, XW'(0), YW'(0), 3'b000, ~HP, ~VP, 12'h000});
        end
        rst = 1'b1;
        t0 = cyc;
        q.delete();
        hist.delete();
        tmh.delete();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("pix_ce_missing", 32'(pix_ce), 32'd1);
                void'(q.pop_front());
            end
            if (pix_ce) begin
                if (q.size() == 0) begin
                    chk("pix_ce_spurious", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("pix_ce_time", cyc, e.cyc);
                    chk("xy", {x, y}, {e.x, e.y});
                    chk("strobes", {de_early, line_start, frame_start}, e.st);
                    chk("sync", {hs, vs}, e.sy);
                    chk("pins", {r, g, b}, e.rgb);
                end
            end
        end
    end

    initial begin
        int k, n;
        do_reset(10);
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            rgb_in = 12'($urandom);
            test_mode = 1'($urandom);
            k = cyc - t0;
            if (k > 0 && k % CD == 0) begin
                n = k / CD - 1;
                hist.push_back(rgb_in);
                tmh.push_back(test_mode);
                q.push_back(model(n, cyc));
            end
            if (i == 2000 || $urandom_range(0, 599) == 0) do_reset($urandom_range(1, 3));
        end
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator and pixel output stage; successor to the fixed-resolution display_test block used by the 4kmania renderer. Derives a pixel-enable from the system clock and generates h/v counters, sync, data-enable and frame/line strobes. Registers renderer RGB onto the pins with sync/DE delayed to match a configurable renderer latency. Sits between the note/playfield renderer and the board VGA connector.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 4, system clocks per pixel (>=1)
HS_POL, 0, hs level during sync pulse (0 = active-low)
VS_POL, 0, vs level during sync pulse
XW, 10, x width; must hold H_TOTAL-1
YW, 10, y width; must hold V_TOTAL-1
RGB_LAT, 1, renderer latency from x/y to rgb_in, in pixel periods (0..7)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
pix_ce  out  1  one-clk pixel strobe
x  out  XW  current horizontal count, 0..H_TOTAL-1
y  out  YW  current vertical count, 0..V_TOTAL-1
de_early  out  1  x/y inside active area (undelayed)
line_start  out  1  one-pix_ce pulse at x==0
frame_start  out  1  one-pix_ce pulse at x==0,y==0
rgb_in  in  12  {r,g,b} 4 bits each from renderer
test_mode  in  1  colour-bar select (used only with optional feature)
hs  out  1  horizontal sync to pin
vs  out  1  vertical sync to pin
r  out  4  red to pin
g  out  4  green to pin
b  out  4  blue to pin

Behaviour:
- Reset: clk rising edge with rst==0. Only clock and reset are fixed: one clock, synchronous active-low reset, ports named clk and rst.
- H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters.
- Outputs during reset:
  - div_cnt, x, y = 0; pix_ce = 0.
  - de_early, line_start, frame_start = 0.
  - hs = ~HS_POL; vs = ~VS_POL; r, g, b = 0.
  - Delay pipes cleared to the inactive state.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_ce is a registered output, high for one clk when div_cnt==CLK_DIV-1.
  - With CLK_DIV==1, pix_ce is high every clk from the first clk after reset release.
- Counters (advance only on the clk where pix_ce==1):
  - x increments and wraps H_TOTAL-1 -> 0.
  - y increments when x wraps, and itself wraps V_TOTAL-1 -> 0.
  - First pix_ce after reset presents x=0, y=0.
- Strobes (registered with the counters; hold their value between pix_ce):
  - de_early = (x < H_ACTIVE) && (y < V_ACTIVE).
  - line_start = (x == 0); frame_start = line_start && (y == 0).
- Raw sync:
  - hs_raw asserted while H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw asserted while V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, for whole lines (changes on x==0).
- Output alignment:
  - hs_raw, vs_raw and de_early pass through an RGB_LAT-stage shift register clocked by pix_ce, then one output register.
  - hs = delayed hs_raw ? HS_POL : ~HS_POL; vs likewise.
  - {r,g,b} = delayed de ? rgb_in : 0, registered on pix_ce.
  - Net result: pin pixel for coordinate (X,Y) appears RGB_LAT+1 pixel periods after x==X, y==Y are presented, together with its own sync levels.
- Boundaries:
  - Pins blank (r=g=b=0) throughout porches and sync, regardless of rgb_in.
  - rgb_in is sampled only on pix_ce clks.
- Reset mid-frame: all state returns to reset values on the next clk; counting restarts at x=0, y=0; no partial sync pulse is extended.
- Elaboration error (generate/initial check) if:
  - CLK_DIV < 1, or RGB_LAT > 7;
  - H_TOTAL > 2^XW, or V_TOTAL > 2^YW;
  - any sync or active parameter is 0.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: while test_mode==1, the pin colour in the active area is replaced by 8 equal vertical colour bars.
  - Bar index = (delayed x * 8) / H_ACTIVE.
  - Colours in order: white, yellow, cyan, green, magenta, red, blue, black; components 4'hF or 4'h0.
  - Delayed x is aligned through the same pipe as de, so the bars respect RGB_LAT.
- Not defined: test_mode is ignored; no pattern logic is synthesised.

Test Plan:
- Defaults, rst held 0 for 10 clk then 1 -> during reset hs=vs=1 and r=g=b=0; first pix_ce at clk 4 after release; frame_start pulses every 1,680,000 clk.
- Defaults -> line_start period 3200 clk; hs low for exactly 384 clk per line; vs low for exactly 6400 clk per frame; de_early high for 640 consecutive pixels on y=0..479 and never on y>=480.
- Small config (H 8/2/2/2, V 4/1/1/1, CLK_DIV=1, RGB_LAT=2), rgb_in driven as {x[3:0],y[3:0],4'h5} -> pin pixel appears 3 pix_ce after its x/y; r=g=b=0 when x>=8 or y>=4; hs low at x=10..11 delayed by 3.
- HS_POL=1, VS_POL=1 -> sync pulses high; idle levels low; timing identical to the default-polarity case.
- rst pulsed low for 1 clk at y=300, x=500 -> next clk x=y=0, outputs at reset values; next frame_start after exactly one full frame from the restart.
- With VGA_TEST_PATTERN_EN, defaults, test_mode=1 -> pins on active pixel x=0..79 are F/F/F, and on x=560..639 are 0/0/0; test_mode=0 passes rgb_in through.
